booth_mult: RTL
===============

# booth_mult

Sequential radix-2 Booth multiplier for two's-complement operands. It sits directly downstream of the switch-capture register that packs the board switches into the 8-bit operand bus. It accepts operand A (multiplicand) and operand B (multiplier) through a valid/ready handshake and iterates one Booth step per clock. It then presents the 2·WIDTH-bit signed product to the display/output stage through a second valid/ready handshake.

## Interface
- WIDTH, 8, operand width in bits; legal range ≥ 2.
- clk  input  1  single system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands on switch_A/switch_B are valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- switch_A  input  WIDTH  multiplicand, signed two's complement.
- switch_B  input  WIDTH  multiplier, signed two's complement.
- out_valid  output  1  product is valid (high only in DONE).
- out_ready  input  1  downstream consumes product.
- product  output  2·WIDTH  signed product A·B; registered.
- busy  output  1  high in CALC.

## Operation
- States:
  - IDLE: in_ready=1.
  - CALC: busy=1.
  - DONE: out_valid=1.
- IDLE → CALC when in_valid & in_ready at a clock edge. The same edge loads:
  - M ← sign-extend(switch_A) to WIDTH+1 bits.
  - ACC ← 0, WIDTH+1 bits.
  - Q ← switch_B.
  - q_1 ← 0.
  - cnt ← 0.
- Operands are sampled only at the accept edge. Later changes on switch_A/switch_B have no effect.
- Each CALC edge performs one Booth step on {Q[0], q_1}:
  - 01: ACC ← ACC + M.
  - 10: ACC ← ACC − M.
  - 00/11: ACC unchanged.
  - Then arithmetic-shift right {ACC, Q, q_1} by one; ACC MSB is replicated.
  - Then cnt ← cnt + 1.
- ACC is WIDTH+1 bits so that ACC − M with A = −2^(WIDTH−1) cannot overflow. All add/sub is modulo 2^(WIDTH+1).
- The step where cnt reaches WIDTH−1 is the last step. At that same edge:
  - Move to DONE.
  - product ← {ACC[WIDTH−1:0], Q} of the post-shift value.
- DONE → IDLE on an edge with out_ready=1. product holds its value until the next DONE load.
- in_valid is ignored outside IDLE; in_ready is low there.
- out_valid is never asserted outside DONE. out_ready outside DONE has no effect.
- cnt counter width is $clog2(WIDTH+1). It never wraps within an operation.

## Timing
- Reset (async assert, any state): state=IDLE, in_ready=1, out_valid=0, busy=0, product=0, ACC/Q/q_1/M/cnt=0.
- Reset mid-CALC or mid-DONE aborts the operation; the result is discarded.
- Deassertion of rst_n is taken synchronously to clk.
- Latency:
  - Accept at edge 0.
  - Booth steps at edges 1..WIDTH.
  - out_valid high after edge WIDTH, i.e. WIDTH cycles after accept. For WIDTH=8: 8 cycles.
- Handshake completion at edge D (out_ready=1) returns to IDLE. in_ready rises after edge D; there is no same-cycle bypass from DONE to accept.
- Minimum initiation interval is WIDTH+2 cycles: accept + WIDTH steps + 1 DONE cycle.
- out_ready low in DONE stalls indefinitely; product and out_valid are held stable.
- All outputs are registered or decoded from the state register only. There is no combinational path from inputs to outputs.

## Test plan
- Basic sign cases, WIDTH=8:
  - A=3, B=5, in_valid pulse, out_ready=1 → out_valid exactly 8 cycles after accept, product=0x000F, then in_ready=1 one cycle later.
  - A=−3 (0xFD), B=5 → product=0xFFF1.
  - A=5, B=−3 → product=0xFFF1.
  - A=0, B=0x7F → product=0x0000.
- Extremes:
  - A=−128, B=−128 → product=0x4000.
  - A=127, B=−128 → product=0xC080.
  - A=−128, B=127 → product=0xC080 (checks the WIDTH+1 accumulator).
- Backpressure: out_ready=0 for 5 cycles in DONE → out_valid stays 1 and product is stable. During CALC/DONE, toggle in_valid with new operands → no accept, in_ready=0, result unchanged.
- Operand change after accept: A=7, B=9 accepted, then switch_A/B changed every cycle during CALC → product=0x003F.
- Reset mid-operation: assert rst_n=0 at step 4 of CALC → immediately IDLE, busy=0, product=0. Next accept of A=2, B=−2 → product=0xFFFC.
- Exhaustive: all 65,536 A/B pairs with random out_ready stalls → product equals the signed reference model, and latency is always 8 cycles.

Source files
------------

// File: rtl/booth_mult_if.sv
// Handshake bundle between the switch-capture register, the Booth multiplier
// and the display stage.
interface booth_mult_if #(
  parameter int WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     switch_A;
  logic [WIDTH-1:0]     switch_B;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;

  modport master (
    output in_valid, switch_A, switch_B, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, switch_A, switch_B, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/booth_mult.sv
// Sequential radix-2 Booth multiplier: one Booth step per clock, signed
// product presented through a valid/ready handshake.
//
// state  | meaning
// IDLE   | waiting for operands, in_ready high
// CALC   | one Booth step per edge, busy high
// DONE   | product held, out_valid high until out_ready
module booth_mult #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  booth_mult_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [WIDTH:0]       r_acc;
  logic [WIDTH:0]       r_m;
  logic [WIDTH-1:0]     r_q;
  logic                 r_q1;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_product;

  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_acc_sh;
  logic [WIDTH-1:0]     w_q_sh;
  logic                 w_accept;
  logic                 w_last;
  logic                 w_in_ready;
  logic                 w_out_valid;
  logic                 w_busy;

  assign w_accept = bus.in_valid && (r_state == S_IDLE);
  assign w_last   = (r_state == S_CALC) && (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_next = S_CALC;
      end
      S_CALC: begin
        w_busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Booth recode on {Q[0], q_1}; the extra ACC bit absorbs ACC - M when A is the most negative value
  always_comb begin
    w_sum = r_acc;
    case ({r_q[0], r_q1})
      2'b01:   w_sum = r_acc + r_m;
      2'b10:   w_sum = r_acc - r_m;
      default: w_sum = r_acc;
    endcase
  end

  assign w_acc_sh = {w_sum[WIDTH], w_sum[WIDTH:1]};
  assign w_q_sh   = {w_sum[0], r_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_m       <= '0;
      r_q       <= '0;
      r_q1      <= 1'b0;
      r_cnt     <= '0;
      r_product <= '0;
    end else if (w_accept) begin
      r_m   <= {bus.switch_A[WIDTH-1], bus.switch_A};
      r_acc <= '0;
      r_q   <= bus.switch_B;
      r_q1  <= 1'b0;
      r_cnt <= '0;
    end else if (r_state == S_CALC) begin
      r_acc <= w_acc_sh;
      r_q   <= w_q_sh;
      r_q1  <= r_q[0];
      r_cnt <= r_cnt + CW'(1);
      if (w_last) r_product <= {w_acc_sh[WIDTH-1:0], w_q_sh};
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.busy      = w_busy;
  assign bus.product   = r_product;
endmodule
